// File: rtl/board_sequencer_if.sv
// Signal bundle between the board sequencer and the player/VGA logic around it.
// The slave modport is the sequencer's view; master is the driving environment.
interface board_sequencer_if;
    logic        vsync_in;
    logic        start;
    logic        kill_L;
    logic        kill_R;
    logic [11:0] xpos_playerL;
    logic [11:0] xpos_playerR;
    logic [2:0]  board_out;
    logic [1:0]  adv_out;
    logic        busy;
    logic        board_changed;
    logic        respawn;
    logic        game_over;
    logic [1:0]  winner;

    modport master (
        output vsync_in, start, kill_L, kill_R, xpos_playerL, xpos_playerR,
        input  board_out, adv_out, busy, board_changed, respawn, game_over, winner
    );

    modport slave (
        input  vsync_in, start, kill_L, kill_R, xpos_playerL, xpos_playerR,
        output board_out, adv_out, busy, board_changed, respawn, game_over, winner
    );
endinterface

// File: rtl/board_sequencer.sv
// Board (room) index sequencer: tracks right-of-way, steps the board when the
// advantaged player leaves the screen, freezes play between boards, declares a winner.
module board_sequencer #(
    parameter logic [11:0] EDGE_LEFT    = 12'd10,
    parameter logic [11:0] EDGE_RIGHT   = 12'd1014,
    parameter logic [2:0]  BOARD_MIN    = 3'd1,
    parameter logic [2:0]  BOARD_MAX    = 3'd5,
    parameter logic [2:0]  BOARD_START  = 3'd3,
    parameter logic [7:0]  TRANS_FRAMES = 8'd32
) (
    input  logic              clk,
    input  logic              reset,
    board_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_TRANS = 2'd2,
        ST_WIN   = 2'd3
    } state_t;

    localparam logic [1:0] ADV_NONE = 2'd0;
    localparam logic [1:0] ADV_L    = 2'd1;
    localparam logic [1:0] ADV_R    = 2'd2;

    state_t      state_r, state_s;
    logic        vsync_q_r;
    logic        tick_s;
    logic [7:0]  cnt_r, cnt_s;
    logic [2:0]  board_r, board_s;
    logic [1:0]  adv_r, adv_s;
    logic [1:0]  winner_r, winner_s;
    logic        busy_r, busy_s;
    logic        changed_r, changed_s;
    logic        respawn_r, respawn_s;
    logic        over_r, over_s;

    assign tick_s = bus.vsync_in & ~vsync_q_r;

    // Next-state, board stepping, frame countdown and advantage decode.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        board_s   = board_r;
        adv_s     = adv_r;
        winner_s  = winner_r;
        changed_s = 1'b0;
        respawn_s = 1'b0;

        case (state_r)
            ST_IDLE, ST_WIN: begin
                if (bus.start) begin
                    state_s  = ST_PLAY;
                    board_s  = BOARD_START;
                    adv_s    = ADV_NONE;
                    winner_s = 2'd0;
                    cnt_s    = 8'd0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_PLAY: begin
                // Crossing decisions use the advantage held before this cycle's kills.
                if (tick_s && (adv_r == ADV_R) && (bus.xpos_playerR < EDGE_LEFT)) begin
                    if (board_r == BOARD_MIN) begin
                        state_s  = ST_WIN;
                        winner_s = ADV_R;
                    end else begin
                        state_s   = ST_TRANS;
                        board_s   = board_r - 3'd1;
                        changed_s = 1'b1;
                        cnt_s     = TRANS_FRAMES;
                    end
                end else if (tick_s && (adv_r == ADV_L) && (bus.xpos_playerL > EDGE_RIGHT)) begin
                    if (board_r == BOARD_MAX) begin
                        state_s  = ST_WIN;
                        winner_s = ADV_L;
                    end else begin
                        state_s   = ST_TRANS;
                        board_s   = board_r + 3'd1;
                        changed_s = 1'b1;
                        cnt_s     = TRANS_FRAMES;
                    end
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_TRANS: begin
                if (tick_s) begin
                    if (cnt_r <= 8'd1) begin
                        state_s   = ST_PLAY;
                        cnt_s     = 8'd0;
                        respawn_s = 1'b1;
                    end else begin
                        cnt_s = cnt_r - 8'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if ((state_r == ST_PLAY) || (state_r == ST_TRANS)) begin
            case ({bus.kill_L, bus.kill_R})
                2'b10:   adv_s = ADV_L;
                2'b01:   adv_s = ADV_R;
                2'b11:   adv_s = ADV_NONE;
                default: adv_s = adv_r;
            endcase
        end else begin
            adv_s = adv_s;
        end

        busy_s = (state_s != ST_PLAY);
        over_s = (state_s == ST_WIN);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            vsync_q_r <= 1'b0;
            cnt_r     <= 8'd0;
            board_r   <= BOARD_START;
            adv_r     <= ADV_NONE;
            winner_r  <= 2'd0;
            busy_r    <= 1'b1;
            changed_r <= 1'b0;
            respawn_r <= 1'b0;
            over_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            vsync_q_r <= bus.vsync_in;
            cnt_r     <= cnt_s;
            board_r   <= board_s;
            adv_r     <= adv_s;
            winner_r  <= winner_s;
            busy_r    <= busy_s;
            changed_r <= changed_s;
            respawn_r <= respawn_s;
            over_r    <= over_s;
        end
    end

    assign bus.board_out     = board_r;
    assign bus.adv_out       = adv_r;
    assign bus.busy          = busy_r;
    assign bus.board_changed = changed_r;
    assign bus.respawn       = respawn_r;
    assign bus.game_over     = over_r;
    assign bus.winner        = winner_r;

endmodule
